// File: rtl/rr_mux_arbiter.sv
// N-channel valid/ready mux into one registered output beat.
// Fixed-select or round-robin grant; the output register refills in the same cycle it drains.
module rr_mux_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 8,
  parameter int unsigned SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_ch
);

  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SELW-1:0] rr_g, grant;
  logic            rr_ok, fixed_ok, grant_ok, load, take;

  // First requester at or after rr_ptr, wrapping modulo N.
  always_comb begin : rr_scan
    int unsigned idx;
    idx   = 0;
    rr_g  = '0;
    rr_ok = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!rr_ok && in_valid[idx[SELW-1:0]]) begin
        rr_ok = 1'b1;
        rr_g  = idx[SELW-1:0];
      end
    end
  end

  always_comb begin
    fixed_ok = (32'(sel) < N) && in_valid[sel];
    grant    = mode ? rr_g : sel;
    grant_ok = mode ? rr_ok : fixed_ok;
    load     = !out_valid || out_ready;
    take     = load && grant_ok && !rst;
    rr_ptr_d = (32'(grant) == N - 1) ? '0 : grant + 1'b1;
  end

  always_comb begin
    in_ready = '0;
    if (take) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr_q  <= '0;
    end else if (load) begin
      if (grant_ok) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grant*WIDTH +: WIDTH];
        out_ch    <= grant;
        if (mode) rr_ptr_q <= rr_ptr_d;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
